pc_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit RISC core: owns the program counter, feeds it to the PC+2 adder and takes the incremented address back, issues word requests to instruction memory, and buffers returned instructions in a 2-slot in-order queue for decode. Branch/jump redirects flush the queue and discard in-flight responses.

---
 rtl/pc_fetch_if.sv | 33 +++
 rtl/pc_fetch_unit.sv | 114 +++++++++++
 tb/tb_pc_fetch_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and
// the decode-side instruction handoff.
interface pc_fetch_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   // Handshakes: a transfer happens on a rising edge where valid && ready; the
   // producer may drop valid only after that transfer, and data is stable while
   // valid is high and ready is low. Memory responses carry no ready.
   logic               imem_req_valid;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instr;
   logic [ADDR_W-1:0]  if_pc;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_addr, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_addr, if_ready
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: owns the PC, issues word requests and keeps a 2-slot
// in-order queue of fetched instructions; redirects flush and drop stale data.
module pc_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pc_cur,
   input  logic [ADDR_W-1:0] pc_plus2,
   pc_fetch_if.master        bus
);
   typedef enum logic [1:0] {
      SLOT_EMPTY   = 2'd0,
      SLOT_PENDING = 2'd1,
      SLOT_FULL    = 2'd2
   } slot_state_e;

   slot_state_e        slot_st_q [2];
   slot_state_e        slot_st_d [2];
   logic [ADDR_W-1:0]  slot_pc_q [2];
   logic [INSTR_W-1:0] slot_instr_q [2];
   logic               head_q, head_d, tail_q, tail_d;
   logic [1:0]         alloc_q, alloc_d, drop_cnt_q, drop_cnt_d;
   logic [ADDR_W-1:0]  pc_d;

   logic [2:0] occupancy;
   logic [1:0] n_pend;
   logic       issue, deq, fill, pend_any, pend_idx, rsp_dec;

   always_comb begin
      occupancy = {1'b0, alloc_q} + {1'b0, drop_cnt_q};
      // Issue looks only at registered occupancy, never at this cycle's dequeue.
      bus.imem_req_valid = !bus.redirect_valid && (occupancy < 3'd2);
      bus.imem_req_addr  = pc_cur;
      bus.if_valid       = (slot_st_q[head_q] == SLOT_FULL) && !bus.redirect_valid;
      bus.if_instr       = slot_instr_q[head_q];
      bus.if_pc          = slot_pc_q[head_q];
      issue = bus.imem_req_valid && bus.imem_req_ready;
      deq   = bus.if_valid && bus.if_ready;

      n_pend = {1'b0, slot_st_q[0] == SLOT_PENDING} + {1'b0, slot_st_q[1] == SLOT_PENDING};
      pend_any = 1'b0;
      pend_idx = head_q;
      if (slot_st_q[head_q] == SLOT_PENDING) begin
         pend_any = 1'b1;
      end else if (slot_st_q[~head_q] == SLOT_PENDING) begin
         pend_any = 1'b1;
         pend_idx = ~head_q;
      end
      fill = 1'b0;

      slot_st_d  = slot_st_q;
      head_d     = head_q;
      tail_d     = tail_q;
      alloc_d    = alloc_q;
      drop_cnt_d = drop_cnt_q;
      pc_d       = pc_cur;
      // A response counts against outstanding work only if some exists.
      rsp_dec    = bus.imem_rsp_valid && ((drop_cnt_q != 2'd0) || pend_any);

      if (bus.redirect_valid) begin
         slot_st_d[0] = SLOT_EMPTY;
         slot_st_d[1] = SLOT_EMPTY;
         head_d       = 1'b0;
         tail_d       = 1'b0;
         alloc_d      = 2'd0;
         pc_d         = {bus.redirect_addr[ADDR_W-1:1], 1'b0};
         drop_cnt_d   = drop_cnt_q + n_pend - {1'b0, rsp_dec};
      end else begin
         if (deq) begin
            slot_st_d[head_q] = SLOT_EMPTY;
            head_d            = ~head_q;
         end
         if (bus.imem_rsp_valid && (drop_cnt_q != 2'd0)) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
         end else if (bus.imem_rsp_valid && pend_any) begin
            fill                = 1'b1;
            slot_st_d[pend_idx] = SLOT_FULL;
         end
         if (issue) begin
            slot_st_d[tail_q] = SLOT_PENDING;
            tail_d            = ~tail_q;
            pc_d              = pc_plus2;
         end
         alloc_d = alloc_q + {1'b0, issue} - {1'b0, deq};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_cur     <= RESET_PC;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         alloc_q    <= 2'd0;
         drop_cnt_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            slot_st_q[i]    <= SLOT_EMPTY;
            slot_pc_q[i]    <= '0;
            slot_instr_q[i] <= '0;
         end
      end else begin
         pc_cur     <= pc_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         alloc_q    <= alloc_d;
         drop_cnt_q <= drop_cnt_d;
         slot_st_q  <= slot_st_d;
         if (issue) slot_pc_q[tail_q] <= pc_cur;
         if (fill) slot_instr_q[pend_idx] <= bus.imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: queue-based reference of the fetch stream, a
// latency-k memory model, directed scenarios and a RESET_PC wrap instance.
module tb_pc_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst2_n = 1'b0;
   logic [15:0] pc_cur, pc_plus2, pc_cur2, pc_plus2_2;

   pc_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus ();
   pc_fetch_if #(.ADDR_W(16), .INSTR_W(16)) bus2 ();

   pc_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_plus2(pc_plus2), .bus(bus)
   );
   pc_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFC)) dut2 (
      .clk(clk), .rst_n(rst2_n), .pc_cur(pc_cur2), .pc_plus2(pc_plus2_2), .bus(bus2)
   );

   assign pc_plus2   = pc_cur + 16'd2;
   assign pc_plus2_2 = pc_cur2 + 16'd2;

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: requests in flight (with stale flag) and buffered words.
   logic [15:0] inf_pc[$];
   logic        inf_stale[$];
   int          inf_due[$];
   logic [15:0] buf_pc[$];
   logic [15:0] buf_instr[$];
   logic [15:0] exp_req_addr;
   int          cyc;
   int          k;
   logic        mem_rdy;

   logic [15:0] got_pc[$];
   logic [15:0] got_cyc[$];
   logic [15:0] acc_addr[$];
   logic [15:0] got2[$];

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   function automatic logic [15:0] qat(input logic [15:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 16'hDEAD;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int nk);
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr  = 16'h0;
      bus.if_ready       = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 16'h0;
      bus.imem_req_ready = 1'b1;
      inf_pc.delete(); inf_stale.delete(); inf_due.delete();
      buf_pc.delete(); buf_instr.delete();
      got_pc.delete(); got_cyc.delete(); acc_addr.delete();
      exp_req_addr = 16'h0000;
      cyc = 0;
      k = nk;
      mem_rdy = 1'b1;
      @(posedge clk); #1;
      chk("rst_if_valid", bus.if_valid, 1'b0);
      chk("rst_if_instr", bus.if_instr, 16'h0);
      chk("rst_if_pc", bus.if_pc, 16'h0);
      chk("rst_req_valid", bus.imem_req_valid, 1'b1);
      chk("rst_req_addr", bus.imem_req_addr, 16'h0000);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One clock cycle: drive memory and controls, compare at the falling edge,
   // then advance the reference by what that cycle's handshakes did.
   task automatic step(input logic rdy, input logic redir, input logic [15:0] raddr);
      logic        rsp_v, exp_rv, exp_ifv, s;
      logic [15:0] p;
      int          d;
      rsp_v = (inf_due.size() > 0) && (inf_due[0] == cyc);
      bus.imem_rsp_valid = rsp_v;
      bus.imem_rsp_data  = rsp_v ? mem_word(inf_pc[0]) : 16'h0;
      bus.imem_req_ready = mem_rdy;
      bus.if_ready       = rdy;
      bus.redirect_valid = redir;
      bus.redirect_addr  = raddr;
      @(negedge clk);
      exp_rv  = !redir && ((inf_pc.size() + buf_pc.size()) < 2);
      exp_ifv = !redir && (buf_pc.size() > 0);
      chk("imem_req_valid", bus.imem_req_valid, exp_rv);
      chk("imem_req_addr", bus.imem_req_addr, exp_req_addr);
      chk("pc_cur", pc_cur, exp_req_addr);
      chk("if_valid", bus.if_valid, exp_ifv);
      if (exp_ifv) begin
         chk("if_pc", bus.if_pc, buf_pc[0]);
         chk("if_instr", bus.if_instr, buf_instr[0]);
      end
      if (bus.if_valid && rdy) begin
         got_pc.push_back(bus.if_pc);
         got_cyc.push_back(16'(cyc));
      end
      if (bus.imem_req_valid && mem_rdy) acc_addr.push_back(bus.imem_req_addr);

      if (exp_ifv && rdy) begin
         p = buf_pc.pop_front();
         p = buf_instr.pop_front();
      end
      if (rsp_v) begin
         p = inf_pc.pop_front();
         s = inf_stale.pop_front();
         d = inf_due.pop_front();
         if (!s && !redir) begin
            buf_pc.push_back(p);
            buf_instr.push_back(mem_word(p));
         end
      end
      if (exp_rv && mem_rdy) begin
         inf_pc.push_back(exp_req_addr);
         inf_stale.push_back(1'b0);
         inf_due.push_back(cyc + k);
         exp_req_addr = exp_req_addr + 16'd2;
      end
      if (redir) begin
         buf_pc.delete();
         buf_instr.delete();
         foreach (inf_stale[i]) inf_stale[i] = 1'b1;
         exp_req_addr = {raddr[15:1], 1'b0};
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      logic [7:0]  rpat;
      logic [4:0]  dpat;
      logic        pend2;
      logic [15:0] pend2_a;
      rpat = 8'b1101_0111;
      dpat = 5'b10110;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_addr  = 16'h0;
      bus2.if_ready       = 1'b1;
      bus2.imem_req_ready = 1'b1;
      bus2.imem_rsp_valid = 1'b0;
      bus2.imem_rsp_data  = 16'h0;

      // Sequential fetch, k=1, decode always ready.
      do_reset(1);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 16'h0);
      chk("seq_pc0", qat(got_pc, 0), 16'h0000);
      chk("seq_pc1", qat(got_pc, 1), 16'h0002);
      chk("seq_pc2", qat(got_pc, 2), 16'h0004);
      chk("seq_pc3", qat(got_pc, 3), 16'h0006);
      chk("seq_first_cycle", qat(got_cyc, 0), 16'd2);
      chk("seq_throughput", got_pc.size(), 32'd7);

      // Decode stalled 10 cycles, then released.
      do_reset(1);
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 16'h0);
      chk("stall_req_count", acc_addr.size(), 32'd2);
      chk("stall_req0", qat(acc_addr, 0), 16'h0000);
      chk("stall_req1", qat(acc_addr, 1), 16'h0002);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 16'h0);
      chk("stall_out0", qat(got_pc, 0), 16'h0000);
      chk("stall_out1", qat(got_pc, 1), 16'h0002);
      chk("stall_out0_cycle", qat(got_cyc, 0), 16'd10);

      // Two requests in flight at k=3, redirect to an odd address.
      do_reset(3);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h0101);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 16'h0);
      chk("redir_req_addr", qat(acc_addr, 2), 16'h0100);
      chk("redir_first_pc", qat(got_pc, 0), 16'h0100);
      chk("redir_first_cycle", qat(got_cyc, 0), 16'd8);

      // Redirect with a response in the same cycle leaving one to discard, k=2.
      do_reset(2);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h0200);
      for (int c = 0; c < 8; c++) step(1'b1, 1'b0, 16'h0);
      chk("redir2_pc0", qat(got_pc, 0), 16'h0000);
      chk("redir2_pc1", qat(got_pc, 1), 16'h0002);
      chk("redir2_target", qat(got_pc, 2), 16'h0200);
      chk("redir2_target_cycle", qat(got_cyc, 2), 16'd10);

      // Redirect while head is full, a response arrives and decode is ready, k=1.
      do_reset(1);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'h2000);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 16'h0);
      chk("redir3_target", qat(got_pc, 0), 16'h2000);
      chk("redir3_target_cycle", qat(got_cyc, 0), 16'd5);

      // Mixed memory/decode backpressure with two redirects, one near the top.
      do_reset(2);
      for (int c = 0; c < 40; c++) begin
         mem_rdy = rpat[c % 8];
         if (c == 17) step(dpat[c % 5], 1'b1, 16'h0341);
         else if (c == 29) step(dpat[c % 5], 1'b1, 16'hFFFF);
         else step(dpat[c % 5], 1'b0, 16'h0);
      end

      // Asynchronous reset with both slots full.
      do_reset(1);
      for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 16'h0);
      #2;
      chk("pre_async_if_valid", bus.if_valid, 1'b1);
      chk("pre_async_pc_cur", pc_cur, 16'h0004);
      rst_n = 1'b0;
      #1;
      chk("async_if_valid", bus.if_valid, 1'b0);
      chk("async_pc_cur", pc_cur, 16'h0000);
      chk("async_if_pc", bus.if_pc, 16'h0000);
      do_reset(1);

      // Second instance: RESET_PC near the top of the address space.
      @(posedge clk); #1;
      rst2_n = 1'b1;
      chk("wrap_reset_pc", pc_cur2, 16'hFFFC);
      pend2 = 1'b0;
      pend2_a = 16'h0;
      for (int c = 0; c < 10; c++) begin
         bus2.imem_rsp_valid = pend2;
         bus2.imem_rsp_data  = pend2 ? mem_word(pend2_a) : 16'h0;
         @(negedge clk);
         if (bus2.if_valid) begin
            got2.push_back(bus2.if_pc);
            chk("wrap_instr", bus2.if_instr, mem_word(bus2.if_pc));
         end
         pend2   = bus2.imem_req_valid;
         pend2_a = bus2.imem_req_addr;
         @(posedge clk); #1;
      end
      chk("wrap_pc0", qat(got2, 0), 16'hFFFC);
      chk("wrap_pc1", qat(got2, 1), 16'hFFFE);
      chk("wrap_pc2", qat(got2, 2), 16'h0000);
      chk("wrap_pc3", qat(got2, 3), 16'h0002);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
